return_addr_stack: RTL and testbench
====================================

// Module: return_addr_stack
// PURPOSE
//  Two-wide return-address stack (RAS) directly downstream of the fetch-stage pre-decoder.
//  - Consumes the per-slot bsr/ret flags.
//  - Pushes the return address for each BSR.
//  - Supplies a predicted target for each RET in the same cycle.
//  - Exposes its pointer/count so the branch checkpoint logic can restore it on a mispredict.
// PARAMETERS
//  DEPTH   16  number of stack entries; power of two, >= 2
//  PTR_W   4   pointer width; must equal log2(DEPTH)
// PORTS
//  clock            in   1        system clock, all state updates on rising edge
//  reset            in   1        synchronous, active-high
//  valid_1          in   1        fetch slot 1 holds a real instruction (slot 1 is older)
//  valid_2          in   1        fetch slot 2 holds a real instruction
//  pc_1             in   64       PC of slot 1
//  pc_2             in   64       PC of slot 2
//  bsr_branch_1     in   1        slot 1 is BSR (from pre-decoder)
//  bsr_branch_2     in   1        slot 2 is BSR
//  ret_branch_1     in   1        slot 1 is RET (from pre-decoder)
//  ret_branch_2     in   1        slot 2 is RET
//  stall            in   1        fetch stalled: no push/pop this cycle
//  recover          in   1        restore pointer/count from checkpoint (mispredict)
//  recover_tos      in   PTR_W    checkpointed top-of-stack pointer
//  recover_count    in   PTR_W+1  checkpointed occupancy
//  ret_target_1     out  64       predicted return target for slot 1
//  ret_target_valid_1 out 1       ret_target_1 usable
//  ret_target_2     out  64       predicted return target for slot 2
//  ret_target_valid_2 out 1       ret_target_2 usable
//  tos_ptr          out  PTR_W    current top-of-stack pointer (for checkpointing)
//  ras_count        out  PTR_W+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//  - State: DEPTH x 64 entry array, tos_ptr (index of the most recent push), ras_count.
//  - Reset: tos_ptr=0, ras_count=0, all entries 0.
//    All outputs read 0 in the cycle after reset.
//    Reset asserted mid-operation discards any push/pop in that cycle.
//  - Lookup is combinational, zero latency, from the registered state.
//    - ret_target_1 = entry[tos_ptr]; ret_target_valid_1 = valid_1 & ret_branch_1 & (ras_count!=0).
//    - Slot 2 is live only if slot 1 is not a redirect: live_2 = valid_2 & ~(valid_1 & (bsr_branch_1|ret_branch_1)).
//    - ret_target_2 = entry[tos_ptr]; ret_target_valid_2 = live_2 & ret_branch_2 & (ras_count!=0).
//    - Whenever a valid output is 0, its target reads 64'h0.
//  - Update happens at the clock edge, only when ~stall & ~recover & ~reset. At most one op per cycle.
//    - Slot 1 BSR (valid_1): push pc_1+4.
//    - Else slot 1 RET (valid_1): pop.
//    - Else slot 2 BSR (live_2): push pc_2+4.
//    - Else slot 2 RET (live_2): pop.
//  - Push: tos_ptr <= tos_ptr+1 (mod DEPTH), entry[new ptr] <= addr, ras_count <= min(ras_count+1, DEPTH).
//    PC+4 wraps modulo 2^64.
//  - Full push overwrites the oldest entry (circular); ras_count stays DEPTH.
//  - Pop: tos_ptr <= tos_ptr-1 (mod DEPTH), ras_count <= ras_count-1.
//  - Pop on empty (ras_count==0): no state change; target valid=0.
//  - Recover: tos_ptr <= recover_tos, ras_count <= recover_count. Entries untouched.
//    Recover has priority over stall and any push/pop in the same cycle.
//    Reset has priority over recover.
//  - Lookup outputs stay driven during stall.
// CONFIGURATION
//  RAS_STATS_EN defined adds two outputs:
//    overflow_cnt  out 16  pushes performed while ras_count==DEPTH
//    underflow_cnt out 16  pops attempted while ras_count==0
//    - Both saturate at 16'hFFFF, reset to 0, unaffected by recover.
//  RAS_STATS_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. Reset, then slot1 BSR pc_1=64'h1000 -> next cycle tos_ptr=1, ras_count=1.
//     Then slot1 RET -> ret_target_1=64'h1004, valid=1; after edge ras_count=0.
//  2. Slot1 BSR pc_1=64'h2000 with slot2 RET the same cycle -> slot2 ignored
//     (ret_target_valid_2=0); only one push; ras_count=1.
//  3. 17 pushes with DEPTH=16, pc = 64'h100*k -> ras_count=16.
//     16 pops return 64'h100*k+4 for k=17 down to 2, then pop on empty -> valid=0
//     (RAS_STATS_EN: overflow_cnt=1, underflow_cnt=1).
//  4. ras_count=3, stall=1 with slot1 BSR -> no state change; held RET lookup still shows entry[tos_ptr].
//  5. Checkpoint tos_ptr=2, ras_count=2; two pushes and one pop; recover with (2,2)
//     in the same cycle as a slot1 BSR -> state (2,2), BSR dropped.
//  6. pc_1=64'hFFFF_FFFF_FFFF_FFFC BSR then RET -> target 64'h0, valid=1.
//     Reset asserted with a concurrent push -> ras_count=0.

Source files
------------

// File: rtl/return_addr_stack.sv
// -----------------------------------------------------------------------------
// return_addr_stack
//   Two-wide return-address stack fed by the fetch-stage pre-decoder.
//   A BSR pushes its PC+4. A RET is given the current top entry as its
//   predicted target. The pointer and count are exposed so the branch
//   checkpoint logic can snapshot them and restore them on a mispredict.
//
//   Ports
//     clock, reset              rising-edge clock, synchronous active-high reset
//     valid_1/2, pc_1/2         fetch slots (slot 1 is the older one)
//     bsr_branch_1/2            pre-decoded BSR flags
//     ret_branch_1/2            pre-decoded RET flags
//     stall                     blocks push/pop for this cycle
//     recover, recover_tos,
//     recover_count             restore pointer/count from a checkpoint
//     ret_target_1/2,
//     ret_target_valid_1/2      zero-latency RET predictions
//     tos_ptr, ras_count        registered stack state, used for checkpointing
//
//   Optional build macro RAS_STATS_EN adds two counters:
//     overflow_cnt              pushes made while the stack was full
//     underflow_cnt             pops attempted while the stack was empty
// -----------------------------------------------------------------------------
module return_addr_stack #(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             valid_1,
   input  logic             valid_2,
   input  logic [63:0]      pc_1,
   input  logic [63:0]      pc_2,
   input  logic             bsr_branch_1,
   input  logic             bsr_branch_2,
   input  logic             ret_branch_1,
   input  logic             ret_branch_2,
   input  logic             stall,
   input  logic             recover,
   input  logic [PTR_W-1:0] recover_tos,
   input  logic [PTR_W:0]   recover_count,
   output logic [63:0]      ret_target_1,
   output logic             ret_target_valid_1,
   output logic [63:0]      ret_target_2,
   output logic             ret_target_valid_2,
   output logic [PTR_W-1:0] tos_ptr,
`ifdef RAS_STATS_EN
   output logic [PTR_W:0]   ras_count,
   output logic [15:0]      overflow_cnt,
   output logic [15:0]      underflow_cnt
`else
   output logic [PTR_W:0]   ras_count
`endif
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   // At most one stack operation is resolved per cycle.
   typedef struct packed {
      logic        push;
      logic        pop;
      logic [63:0] addr;
   } ras_op_t;

   logic [63:0]      entry [DEPTH];
   logic [63:0]      top;
   logic             slot1_redirect;
   logic             live_2;
   logic             nonempty;
   logic             full;
   logic             upd_en;
   logic [PTR_W-1:0] push_ptr;
   ras_op_t          op;

   assign top            = entry[tos_ptr];
   assign nonempty       = (ras_count != '0);
   assign full           = (ras_count == FULL_CNT);
   assign push_ptr       = tos_ptr + 1'b1;
   // A BSR or RET in slot 1 redirects fetch, so slot 2 is on the wrong path.
   assign slot1_redirect = valid_1 & (bsr_branch_1 | ret_branch_1);
   assign live_2         = valid_2 & ~slot1_redirect;
   assign upd_en         = ~stall & ~recover;

   // Both slots look at the same registered top: slot 2 can only be live when
   // slot 1 did nothing to the stack.
   assign ret_target_valid_1 = valid_1 & ret_branch_1 & nonempty;
   assign ret_target_valid_2 = live_2 & ret_branch_2 & nonempty;
   assign ret_target_1       = ret_target_valid_1 ? top : 64'h0;
   assign ret_target_2       = ret_target_valid_2 ? top : 64'h0;

   always_comb begin
      op = '0;
      if (valid_1 & bsr_branch_1) begin
         op.push = 1'b1;
         op.addr = pc_1 + 64'd4;
      end else if (valid_1 & ret_branch_1) begin
         op.pop = 1'b1;
      end else if (live_2 & bsr_branch_2) begin
         op.push = 1'b1;
         op.addr = pc_2 + 64'd4;
      end else if (live_2 & ret_branch_2) begin
         op.pop = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tos_ptr   <= '0;
         ras_count <= '0;
         for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      end else if (recover) begin
         tos_ptr   <= recover_tos;
         ras_count <= recover_count;
      end else if (upd_en) begin
         if (op.push) begin
            // When full, the write lands on the oldest slot (circular overwrite).
            tos_ptr         <= push_ptr;
            entry[push_ptr] <= op.addr;
            if (!full) ras_count <= ras_count + 1'b1;
         end else if (op.pop && nonempty) begin
            tos_ptr   <= tos_ptr - 1'b1;
            ras_count <= ras_count - 1'b1;
         end
      end
   end

`ifdef RAS_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow_cnt  <= '0;
         underflow_cnt <= '0;
      end else if (upd_en) begin
         if (op.push && full && overflow_cnt != 16'hFFFF)
            overflow_cnt <= overflow_cnt + 16'd1;
         if (op.pop && !nonempty && underflow_cnt != 16'hFFFF)
            underflow_cnt <= underflow_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_return_addr_stack.sv
module tb_return_addr_stack;

   logic        clock = 1'b0;
   logic        reset, valid_1, valid_2, bsr_branch_1, bsr_branch_2;
   logic        ret_branch_1, ret_branch_2, stall, recover;
   logic [63:0] pc_1, pc_2;
   logic [3:0]  recover_tos;
   logic [4:0]  recover_count;
   logic [63:0] ret_target_1, ret_target_2;
   logic        ret_target_valid_1, ret_target_valid_2;
   logic [3:0]  tos_ptr;
   logic [4:0]  ras_count;
`ifdef RAS_STATS_EN
   logic [15:0] overflow_cnt, underflow_cnt;
`endif

   return_addr_stack #(.DEPTH(16), .PTR_W(4)) dut (
      .clock(clock), .reset(reset),
      .valid_1(valid_1), .valid_2(valid_2), .pc_1(pc_1), .pc_2(pc_2),
      .bsr_branch_1(bsr_branch_1), .bsr_branch_2(bsr_branch_2),
      .ret_branch_1(ret_branch_1), .ret_branch_2(ret_branch_2),
      .stall(stall), .recover(recover),
      .recover_tos(recover_tos), .recover_count(recover_count),
      .ret_target_1(ret_target_1), .ret_target_valid_1(ret_target_valid_1),
      .ret_target_2(ret_target_2), .ret_target_valid_2(ret_target_valid_2),
      .tos_ptr(tos_ptr),
`ifdef RAS_STATS_EN
      .ras_count(ras_count),
      .overflow_cnt(overflow_cnt), .underflow_cnt(underflow_cnt)
`else
      .ras_count(ras_count)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [63:0] t1;
      logic        v1;
      logic [63:0] t2;
      logic        v2;
      logic [3:0]  tos;
      logic [4:0]  cnt;
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk = 0;
   int          n_err = 0;

   // Reference stack, kept as plain ints.
   logic [63:0] m_ent [16];
   int          m_tos, m_cnt, m_ovf, m_unf;
   logic [63:0] obs_t1, obs_t2;
   logic        obs_v1, obs_v2;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_ent[i] = '0;
      m_tos = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
   endtask

   // Drive one cycle, queue the expected lookup, compare at negedge,
   // then advance the model across the rising edge.
   task automatic step(input logic v1, input logic b1, input logic r1, input logic [63:0] p1,
                       input logic v2, input logic b2, input logic r2, input logic [63:0] p2,
                       input logic st, input logic rc, input logic [3:0] rtos,
                       input logic [4:0] rcnt, input logic rst);
      exp_t e, g;
      logic redir, live, ne, push, pop;
      logic [63:0] addr;
      valid_1 = v1; bsr_branch_1 = b1; ret_branch_1 = r1; pc_1 = p1;
      valid_2 = v2; bsr_branch_2 = b2; ret_branch_2 = r2; pc_2 = p2;
      stall = st; recover = rc; recover_tos = rtos; recover_count = rcnt; reset = rst;

      redir = v1 && (b1 || r1);
      live  = v2 && !redir;
      ne    = (m_cnt > 0);
      e.v1  = v1 && r1 && ne;
      e.v2  = live && r2 && ne;
      e.t1  = e.v1 ? m_ent[m_tos] : 64'h0;
      e.t2  = e.v2 ? m_ent[m_tos] : 64'h0;
      e.tos = 4'(m_tos);
      e.cnt = 5'(m_cnt);
      exp_q.push_back(e);

      @(negedge clock);
      g = exp_q.pop_front();
      obs_t1 = ret_target_1; obs_v1 = ret_target_valid_1;
      obs_t2 = ret_target_2; obs_v2 = ret_target_valid_2;
      chk("tgt1", ret_target_1, g.t1);
      chk("vld1", 64'(ret_target_valid_1), 64'(g.v1));
      chk("tgt2", ret_target_2, g.t2);
      chk("vld2", 64'(ret_target_valid_2), 64'(g.v2));
      chk("tos", 64'(tos_ptr), 64'(g.tos));
      chk("cnt", 64'(ras_count), 64'(g.cnt));
`ifdef RAS_STATS_EN
      chk("ovf", 64'(overflow_cnt), 64'(m_ovf));
      chk("unf", 64'(underflow_cnt), 64'(m_unf));
`endif

      push = 0; pop = 0; addr = '0;
      if (v1 && b1)        begin push = 1; addr = p1 + 64'd4; end
      else if (v1 && r1)   pop = 1;
      else if (live && b2) begin push = 1; addr = p2 + 64'd4; end
      else if (live && r2) pop = 1;

      if (rst) model_reset();
      else if (rc) begin m_tos = int'(rtos); m_cnt = int'(rcnt); end
      else if (!st) begin
         if (push) begin
            if (m_cnt == 16) begin if (m_ovf < 65535) m_ovf++; end
            else m_cnt++;
            m_tos = (m_tos + 1) % 16;
            m_ent[m_tos] = addr;
         end else if (pop) begin
            if (m_cnt == 0) begin if (m_unf < 65535) m_unf++; end
            else begin m_cnt--; m_tos = (m_tos + 15) % 16; end
         end
      end
      @(posedge clock); #1;
   endtask

   task automatic idle();                    step(0,0,0,0, 0,0,0,0, 0,0,0,0,0); endtask
   task automatic do_rst();                  step(0,0,0,0, 0,0,0,0, 0,0,0,0,1); endtask
   task automatic bsr1(input logic [63:0] p); step(1,1,0,p, 0,0,0,0, 0,0,0,0,0); endtask
   task automatic ret1();                    step(1,0,1,0, 0,0,0,0, 0,0,0,0,0); endtask

   initial begin
      valid_1 = 0; valid_2 = 0; bsr_branch_1 = 0; bsr_branch_2 = 0;
      ret_branch_1 = 0; ret_branch_2 = 0; pc_1 = 0; pc_2 = 0;
      stall = 0; recover = 0; recover_tos = 0; recover_count = 0; reset = 1;
      repeat (2) @(posedge clock);
      #1;
      model_reset();
      idle();                                   // reset state, all zero

      // 1. push then pop
      bsr1(64'h1000);
      chk("t1_tos", 64'(tos_ptr), 64'd1);
      chk("t1_cnt", 64'(ras_count), 64'd1);
      ret1();
      chk("t1_tgt", obs_t1, 64'h1004);
      chk("t1_vld", 64'(obs_v1), 64'd1);
      chk("t1_cnt0", 64'(ras_count), 64'd0);

      // 2. slot1 BSR shadows slot2 RET
      step(1,1,0,64'h2000, 1,0,1,0, 0,0,0,0,0);
      chk("t2_v2", 64'(obs_v2), 64'd0);
      chk("t2_cnt", 64'(ras_count), 64'd1);
      step(0,0,0,0, 1,0,1,0, 0,0,0,0,0);        // lone slot2 RET is live
      chk("t2_s2tgt", obs_t2, 64'h2004);

      // 3. overflow and underflow
      do_rst();
      for (int k = 1; k <= 17; k++) bsr1(64'h100 * k);
      chk("t3_full", 64'(ras_count), 64'd16);
      for (int k = 17; k >= 2; k--) begin
         ret1();
         chk("t3_pop", obs_t1, 64'h100 * k + 64'd4);
      end
      ret1();
      chk("t3_empty_v", 64'(obs_v1), 64'd0);
`ifdef RAS_STATS_EN
      idle();
      chk("t3_ovf", 64'(overflow_cnt), 64'd1);
      chk("t3_unf", 64'(underflow_cnt), 64'd1);
`endif

      // 4. stall holds state but lookup stays live
      do_rst();
      bsr1(64'h10); bsr1(64'h20); bsr1(64'h30);
      step(1,1,0,64'h40, 0,0,0,0, 1,0,0,0,0);
      chk("t4_cnt", 64'(ras_count), 64'd3);
      step(1,0,1,0, 0,0,0,0, 1,0,0,0,0);
      chk("t4_tgt", obs_t1, 64'h34);
      chk("t4_tos", 64'(tos_ptr), 64'd3);

      // 5. recover beats a concurrent BSR
      do_rst();
      bsr1(64'h500); bsr1(64'h600);
      bsr1(64'h700); bsr1(64'h800); ret1();
      step(1,1,0,64'h900, 0,0,0,0, 0,1,4'd2,5'd2,0);
      chk("t5_tos", 64'(tos_ptr), 64'd2);
      chk("t5_cnt", 64'(ras_count), 64'd2);
      ret1();
      chk("t5_tgt", obs_t1, 64'h604);

      // 6. PC+4 wrap, reset beats push
      bsr1(64'hFFFF_FFFF_FFFF_FFFC);
      ret1();
      chk("t6_tgt", obs_t1, 64'h0);
      chk("t6_vld", 64'(obs_v1), 64'd1);
      step(1,1,0,64'h1234, 0,0,0,0, 0,0,0,0,1);
      chk("t6_rst", 64'(ras_count), 64'd0);

      // Random mix against the reference model.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom},
              1'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom},
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
              4'($urandom), 5'($urandom_range(0, 16)), ($urandom_range(0, 63) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
